// File: rtl/tlk2711_rd_arb.sv
// Round-robin arbiter sharing one DMA read-command port among NUM_CH channels,
// with an in-order tag FIFO that routes each returned burst back to its issuer.
module tlk2711_rd_arb #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int DLEN_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_DEPTH  = 8,
    localparam int CW = DLEN_WIDTH + ADDR_WIDTH,
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OW = $clog2(TAG_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_soft_rst,
    input  logic [NUM_CH-1:0]        i_ch_cmd_req,
    input  logic [NUM_CH*CW-1:0]     i_ch_cmd_data,
    output logic [NUM_CH-1:0]        o_ch_cmd_ack,
    output logic                     o_rd_cmd_req,
    output logic [CW-1:0]            o_rd_cmd_data,
    input  logic                     i_rd_cmd_ack,
    input  logic                     i_dma_rd_valid,
    input  logic                     i_dma_rd_last,
    input  logic [DATA_WIDTH-1:0]    i_dma_rd_data,
    output logic                     o_dma_rd_ready,
    output logic [NUM_CH-1:0]        o_ch_rd_valid,
    output logic [NUM_CH-1:0]        o_ch_rd_last,
    output logic [DATA_WIDTH-1:0]    o_ch_rd_data,
    input  logic [NUM_CH-1:0]        i_ch_rd_ready,
    output logic [OW-1:0]            o_outstanding,
    output logic [IW-1:0]            o_grant_id,
    output logic                     o_orphan_err
);

    localparam int PW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   sel_id;
    logic            sel_valid;
    logic [IW-1:0]   idx;
    logic            grant_load;
    logic            push;
    logic            pop;
    logic [IW-1:0]   tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [OW-1:0]   count;
    logic            fifo_full, fifo_empty;
    logic [IW-1:0]   head;
    logic [CW-1:0]   ch_cmd [NUM_CH];

    assign fifo_full     = (count == OW'(TAG_DEPTH));
    assign fifo_empty    = (count == '0);
    assign head          = tag_mem[rd_ptr];
    assign o_outstanding = count;
    assign o_ch_rd_data  = i_dma_rd_data;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            ch_cmd[k] = i_ch_cmd_data[k*CW +: CW];
    end

    // First requester at or after rr_ptr, scanning upward modulo NUM_CH.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel_valid = 1'b0;
        sel_id    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = IW'((int'(rr_ptr) + i) % NUM_CH);
            if (!sel_valid && i_ch_cmd_req[idx]) begin
                sel_valid = 1'b1;
                sel_id    = idx;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_load   = 1'b0;
        push         = 1'b0;
        o_ch_cmd_ack = '0;
        unique case (state)
            S_IDLE: if (sel_valid && !fifo_full) begin
                grant_load = 1'b1;
                state_nxt  = S_REQ;
            end
            S_REQ: if (i_rd_cmd_ack) begin
                push                     = 1'b1;
                o_ch_cmd_ack[o_grant_id] = 1'b1;
                state_nxt                = S_GAP;
            end
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Return-data routing follows the oldest outstanding tag.
    always_comb begin
        o_ch_rd_valid  = '0;
        o_ch_rd_last   = '0;
        o_dma_rd_ready = 1'b0;
        if (!fifo_empty) begin
            o_ch_rd_valid[head] = i_dma_rd_valid;
            o_ch_rd_last[head]  = i_dma_rd_last;
            o_dma_rd_ready      = i_ch_rd_ready[head];
        end
    end

    assign pop = i_dma_rd_valid & o_dma_rd_ready & i_dma_rd_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_soft_rst) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            o_grant_id    <= '0;
            o_rd_cmd_req  <= 1'b0;
            o_rd_cmd_data <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_orphan_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_load) begin
                o_rd_cmd_req  <= 1'b1;
                o_rd_cmd_data <= ch_cmd[sel_id];
                o_grant_id    <= sel_id;
            end else if (push) begin
                o_rd_cmd_req <= 1'b0;
            end
            if (push) begin
                rr_ptr <= (o_grant_id == IW'(NUM_CH - 1)) ? '0 : o_grant_id + IW'(1);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
            if (fifo_empty && i_dma_rd_valid)
                o_orphan_err <= 1'b1;
        end
    end

    // NOTE: tag storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= o_grant_id;
    end

endmodule

// File: tb/tb_tlk2711_rd_arb.sv
// Directed bench for tlk2711_rd_arb: grant order, command handshake, tag routing,
// FIFO-full blocking, ready stall, orphan flag and soft reset.
module tb_tlk2711_rd_arb;

    localparam int NUM_CH = 4;
    localparam int CW     = 64;
    localparam int DW     = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_soft_rst;
    logic [NUM_CH-1:0]    i_ch_cmd_req;
    logic [NUM_CH*CW-1:0] i_ch_cmd_data;
    logic [NUM_CH-1:0]    o_ch_cmd_ack;
    logic                 o_rd_cmd_req;
    logic [CW-1:0]        o_rd_cmd_data;
    logic                 i_rd_cmd_ack;
    logic                 i_dma_rd_valid;
    logic                 i_dma_rd_last;
    logic [DW-1:0]        i_dma_rd_data;
    logic                 o_dma_rd_ready;
    logic [NUM_CH-1:0]    o_ch_rd_valid;
    logic [NUM_CH-1:0]    o_ch_rd_last;
    logic [DW-1:0]        o_ch_rd_data;
    logic [NUM_CH-1:0]    i_ch_rd_ready;
    logic [3:0]           o_outstanding;
    logic [1:0]           o_grant_id;
    logic                 o_orphan_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [CW-1:0] cmd_tab [NUM_CH] = '{64'h0100_0000_0000_1000, 64'h0200_0000_0000_2040,
                                        64'h0040_0001_0000_3000, 64'hFFFF_FFFF_FFFF_FFF8};

    tlk2711_rd_arb dut (
        .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst),
        .i_ch_cmd_req(i_ch_cmd_req), .i_ch_cmd_data(i_ch_cmd_data), .o_ch_cmd_ack(o_ch_cmd_ack),
        .o_rd_cmd_req(o_rd_cmd_req), .o_rd_cmd_data(o_rd_cmd_data), .i_rd_cmd_ack(i_rd_cmd_ack),
        .i_dma_rd_valid(i_dma_rd_valid), .i_dma_rd_last(i_dma_rd_last), .i_dma_rd_data(i_dma_rd_data),
        .o_dma_rd_ready(o_dma_rd_ready), .o_ch_rd_valid(o_ch_rd_valid), .o_ch_rd_last(o_ch_rd_last),
        .o_ch_rd_data(o_ch_rd_data), .i_ch_rd_ready(i_ch_rd_ready), .o_outstanding(o_outstanding),
        .o_grant_id(o_grant_id), .o_orphan_err(o_orphan_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!o_rd_cmd_req && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"}, 64'(o_rd_cmd_req), 64'd1);
    endtask

    // Wait for a command, check grant and word, ack after dly cycles; returns in the GAP cycle.
    task automatic issue(input int exp_ch, input int dly, input string tag);
        wait_req(tag);
        check({tag, "_gid"}, 64'(o_grant_id), 64'(exp_ch));
        check({tag, "_cmd"}, o_rd_cmd_data, cmd_tab[exp_ch]);
        for (int d = 0; d < dly; d++) step();
        i_rd_cmd_ack = 1'b1;
        #1;
        check({tag, "_ack"}, 64'(o_ch_cmd_ack), 64'(1) << exp_ch);
        step();
        i_rd_cmd_ack = 1'b0;
        #1;
        check({tag, "_ackoff"}, 64'(o_ch_cmd_ack), 64'd0);
    endtask

    task automatic burst(input int ch, input int beats, input int exp_out, input string tag);
        for (int b = 0; b < beats; b++) begin
            i_dma_rd_valid = 1'b1;
            i_dma_rd_last  = (b == beats - 1);
            i_dma_rd_data  = 64'hD000 + 64'(ch * 256 + b);
            #1;
            check({tag, "_vld"}, 64'(o_ch_rd_valid), 64'(1) << ch);
            check({tag, "_last"}, 64'(o_ch_rd_last), (b == beats - 1) ? (64'(1) << ch) : 64'd0);
            check({tag, "_data"}, o_ch_rd_data, 64'hD000 + 64'(ch * 256 + b));
            step();
        end
        i_dma_rd_valid = 1'b0;
        i_dma_rd_last  = 1'b0;
        #1;
        check({tag, "_out"}, 64'(o_outstanding), 64'(exp_out));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic seen;
        rst            = 1'b1;
        i_soft_rst     = 1'b0;
        i_ch_cmd_req   = '0;
        i_rd_cmd_ack   = 1'b0;
        i_dma_rd_valid = 1'b0;
        i_dma_rd_last  = 1'b0;
        i_dma_rd_data  = '0;
        i_ch_rd_ready  = 4'hF;
        for (int k = 0; k < NUM_CH; k++) i_ch_cmd_data[k*CW +: CW] = cmd_tab[k];

        // Reset values
        step();
        step();
        check("rst_req", 64'(o_rd_cmd_req), 0);
        check("rst_cmd", o_rd_cmd_data, 0);
        check("rst_gid", 64'(o_grant_id), 0);
        check("rst_out", 64'(o_outstanding), 0);
        check("rst_orph", 64'(o_orphan_err), 0);
        check("rst_cack", 64'(o_ch_cmd_ack), 0);
        check("rst_vld", 64'(o_ch_rd_valid), 0);
        check("rst_last", 64'(o_ch_rd_last), 0);
        check("rst_rdy", 64'(o_dma_rd_ready), 0);
        rst = 1'b0;

        // Single command on channel 0, acked two cycles after the request
        i_ch_cmd_req = 4'b0001;
        step();
        check("single_lat", 64'(o_rd_cmd_req), 1);
        issue(0, 2, "single");
        i_ch_cmd_req = '0;
        check("single_reqoff", 64'(o_rd_cmd_req), 0);
        check("single_out", 64'(o_outstanding), 1);
        burst(0, 1, 0, "single_drain");

        // Round robin with all channels requesting
        do_reset();
        i_ch_cmd_req = 4'hF;
        issue(0, 0, "rr0");
        issue(1, 0, "rr1");
        issue(2, 0, "rr2");
        issue(3, 0, "rr3");
        issue(0, 0, "rr4");
        i_ch_cmd_req = '0;

        // Routing of three bursts to ch2, ch0, ch3
        do_reset();
        i_ch_cmd_req = 4'b0100; issue(2, 0, "rt_c2"); i_ch_cmd_req = '0;
        i_ch_cmd_req = 4'b0001; issue(0, 0, "rt_c0"); i_ch_cmd_req = '0;
        i_ch_cmd_req = 4'b1000; issue(3, 0, "rt_c3"); i_ch_cmd_req = '0;
        check("rt_out3", 64'(o_outstanding), 3);
        burst(2, 4, 2, "rt_b2");
        burst(0, 2, 1, "rt_b0");
        burst(3, 3, 0, "rt_b3");

        // Tag FIFO full blocks the ninth command until a burst completes
        do_reset();
        i_ch_cmd_req = 4'hF;
        for (int c = 0; c < 8; c++) issue(c % NUM_CH, 0, "full");
        check("full_out8", 64'(o_outstanding), 8);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            seen |= o_rd_cmd_req;
        end
        check("full_no9th", 64'(seen), 0);
        burst(0, 1, 7, "full_pop");
        issue(0, 0, "full_9th");
        check("full_out8b", 64'(o_outstanding), 8);
        i_ch_cmd_req = '0;

        // Head channel stalls ready for five cycles
        do_reset();
        i_ch_cmd_req = 4'b0010; issue(1, 0, "stall_cmd"); i_ch_cmd_req = '0;
        i_ch_rd_ready  = 4'b1101;
        i_dma_rd_valid = 1'b1;
        i_dma_rd_last  = 1'b0;
        i_dma_rd_data  = 64'hAAAA_0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_rdy", 64'(o_dma_rd_ready), 0);
            check("stall_vld", 64'(o_ch_rd_valid), 64'b0010);
            step();
        end
        check("stall_out", 64'(o_outstanding), 1);
        i_ch_rd_ready = 4'hF;
        #1;
        check("stall_rel", 64'(o_dma_rd_ready), 1);
        check("stall_dataA", o_ch_rd_data, 64'hAAAA_0001);
        step();
        i_dma_rd_last = 1'b1;
        i_dma_rd_data = 64'hAAAA_0002;
        #1;
        check("stall_lastB", 64'(o_ch_rd_last), 64'b0010);
        step();
        i_dma_rd_valid = 1'b0;
        i_dma_rd_last  = 1'b0;
        #1;
        check("stall_done", 64'(o_outstanding), 0);

        // Orphan data, then soft reset in the middle of a request
        i_dma_rd_valid = 1'b1;
        i_dma_rd_last  = 1'b1;
        #1;
        check("orph_rdy", 64'(o_dma_rd_ready), 0);
        check("orph_vld", 64'(o_ch_rd_valid), 0);
        step();
        i_dma_rd_valid = 1'b0;
        i_dma_rd_last  = 1'b0;
        check("orph_set", 64'(o_orphan_err), 1);
        i_ch_cmd_req = 4'b0100; issue(2, 0, "srst_cmd"); i_ch_cmd_req = '0;
        check("orph_hold", 64'(o_orphan_err), 1);
        i_ch_cmd_req = 4'b0100;
        wait_req("srst_wait");
        check("srst_pre_out", 64'(o_outstanding), 1);
        i_soft_rst = 1'b1;
        step();
        i_soft_rst   = 1'b0;
        i_ch_cmd_req = '0;
        check("srst_req", 64'(o_rd_cmd_req), 0);
        check("srst_out", 64'(o_outstanding), 0);
        check("srst_orph", 64'(o_orphan_err), 0);
        check("srst_gid", 64'(o_grant_id), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
